fan_pwm_ctrl: RTL
=================

FAN_PWM_CTRL -- requirements
Module: fan_pwm_ctrl

Interface
REQ-001 Parameter CH, default 4, number of PWM channels (1..16).
REQ-002 Parameter W, default 8, duty/counter width (4..16); PWM period P = 2^W-1 clocks.
REQ-003 Parameter STEP, default 4, max duty change per period while ramping (1..2^W-1).
REQ-004 Parameter KICK, default 2, full-on kick-start periods (0..15).
REQ-005 Parameter INVERT, default 0, 1 = active-low outputs.
REQ-006 Timing: one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  clock, all logic on posedge.
REQ-008 arst  in  1  synchronous active-high reset.
REQ-009 wr_en  in  1  target-duty write strobe, one write per cycle.
REQ-010 wr_ch  in  4  channel index for write.
REQ-011 wr_duty  in  W  target duty; 0 = off, 2^W-1 = 100 %.
REQ-012 pwm_out  out  CH  registered PWM outputs.
REQ-013 busy  out  CH  channel in KICK or RAMP.
REQ-014 period_tick  out  1  one-cycle pulse when shared counter is 0.

Function
REQ-015 Shared counter cnt SHALL count 0..P-1 and wrap to 0; boundary = cycle with cnt==P-1.
REQ-016 wr_en with wr_ch<CH SHALL update that channel's tgt on the next edge; wr_ch>=CH SHALL be ignored.
REQ-017 Each channel SHALL hold cur (applied duty) and state in {OFF, KICK, RAMP, STEADY}; cur/state change only at boundary.
REQ-018 pwm_out[i] at cycle t+1 SHALL equal (cnt(t) < eff_i) XOR INVERT; eff_i = 2^W-1 in KICK, else cur_i.
REQ-019 OFF: cur=0; at boundary with tgt!=0 -> KICK loading kick count KICK; if KICK==0 -> RAMP directly with cur=min(tgt,STEP).
REQ-020 KICK: each boundary decrements kick count; at boundary with count==1 -> RAMP, cur=min(tgt,STEP); tgt==0 at any KICK boundary -> OFF, cur=0.
REQ-021 RAMP: at boundary cur moves toward tgt by min(STEP,|tgt-cur|); result==tgt -> STEADY, or OFF if tgt==0.
REQ-022 STEADY: at boundary with tgt!=cur -> RAMP (first step applied same boundary); tgt==0 path ends in OFF.
REQ-023 Ramp arithmetic SHALL use W+1 bits and saturate at 0 and 2^W-1; no wrap.
REQ-024 Duty changes SHALL never alter a period in progress (glitch-free); a write in the boundary cycle takes effect at that boundary.
REQ-025 busy[i] SHALL be 1 exactly while state_i is KICK or RAMP.
REQ-026 period_tick SHALL be registered, high the cycle after cnt==P-1.

Reset
REQ-027 arst SHALL, on the next edge, set cnt=0, all tgt=0, cur=0, state=OFF, kick count=0.
REQ-028 After reset pwm_out SHALL be all INVERT, busy=0, period_tick=0; arst overrides wr_en in the same cycle.
REQ-029 Reset mid-period SHALL restart the period from cnt=0 on release.

Structure
REQ-030 Shared package fan_pwm_pkg SHALL hold the state enum and derived constant P.
REQ-031 Per-channel logic SHALL be sub-module fan_pwm_channel (tgt, cur, state, kick count, compare), instantiated CH times by generate; counter and tick in top.

Verification (W=8, P=255, STEP=4, KICK=2, CH=4)
REQ-032 Reset asserted mid-period at cnt=100 -> next cycle pwm_out=0000, busy=0, cnt restarts at 0.
REQ-033 Write ch0 duty 128 while OFF -> 2 periods output high all 255 cycles, then duties 4,8,...,128 over 32 periods, busy0 falls at cur=128.
REQ-034 Ch1 STEADY 128, write 0 at cnt=50 -> current period still 128 high cycles; then 124,120,...,0; OFF, output low constantly.
REQ-035 Write 255 and ramp complete -> pwm_out[2] high every cycle; write wr_ch=7 -> no channel changes.
REQ-036 Write 200 to ch3 then 0 during its first KICK period -> OFF at next boundary, pwm low, busy3=0.
REQ-037 INVERT=1 -> post-reset pwm_out=1111; duty 64 steady gives 64 low cycles per 255.

Source files
------------

// File: rtl/fan_pwm_pkg.sv
// fan_pwm_pkg: shared channel state type and PWM period constants
package fan_pwm_pkg;
  typedef enum logic [1:0] {ST_OFF, ST_KICK, ST_RAMP, ST_STEADY} ch_state_e;
  localparam int W_DEF = 8;
  localparam int P = (1 << W_DEF) - 1;
  function automatic int period_of(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/fan_pwm_channel.sv
// fan_pwm_channel: per-channel target/applied duty, kick-start and ramp FSM, PWM compare
module fan_pwm_channel
  import fan_pwm_pkg::*;
#(
  parameter int W      = 8,
  parameter int STEP   = 4,
  parameter int KICK   = 2,
  parameter int INVERT = 0
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         i_wr,
  input  logic [W-1:0] i_duty,
  input  logic [W-1:0] i_cnt,
  input  logic         i_bnd,
  output logic         o_pwm,
  output logic         o_busy
);
  localparam logic [W:0]   STEPX = (W+1)'(STEP);
  localparam logic [W-1:0] STEPW = W'(STEP);
  localparam logic         INV   = 1'(INVERT);
  ch_state_e    r_st, w_st;
  logic [W-1:0] r_tgt, r_cur, w_cur, w_tgt, w_eff, w_first, w_step;
  logic [W:0]   w_dst;
  logic [3:0]   r_kc, w_kc;
  logic         w_up, r_pwm;
  assign w_tgt   = i_wr ? i_duty : r_tgt;
  assign w_eff   = (r_st == ST_KICK) ? '1 : r_cur;
  assign w_first = ({1'b0, w_tgt} < STEPX) ? w_tgt : STEPW;
  assign w_up    = w_tgt > r_cur;
  assign w_dst   = w_up ? {1'b0, w_tgt} - {1'b0, r_cur} : {1'b0, r_cur} - {1'b0, w_tgt};
  // A full step is only taken when the gap exceeds STEP, so it can never overshoot or wrap.
  assign w_step  = (w_dst <= STEPX) ? w_tgt : (w_up ? r_cur + STEPW : r_cur - STEPW);
  assign o_busy  = (r_st == ST_KICK) || (r_st == ST_RAMP);
  assign o_pwm   = r_pwm;
  always_comb begin
    w_st = r_st;
    w_cur = r_cur;
    w_kc = r_kc;
    if (i_bnd) begin
      unique case (r_st)
        ST_OFF: if (w_tgt != '0) begin
          w_st = (KICK == 0) ? ST_RAMP : ST_KICK;
          w_cur = (KICK == 0) ? w_first : '0;
          w_kc = 4'(KICK);
        end
        ST_KICK: begin
          w_st = (w_tgt == '0) ? ST_OFF : (r_kc == 4'd1) ? ST_RAMP : ST_KICK;
          w_cur = (w_tgt == '0) ? '0 : (r_kc == 4'd1) ? w_first : r_cur;
          w_kc = (w_tgt == '0 || r_kc == 4'd1) ? '0 : r_kc - 4'd1;
        end
        default: if (r_st == ST_RAMP || w_tgt != r_cur) begin
          w_cur = w_step;
          w_st = (w_step != w_tgt) ? ST_RAMP : (w_tgt == '0) ? ST_OFF : ST_STEADY;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (arst) begin
      r_tgt <= '0;
      r_cur <= '0;
      r_st <= ST_OFF;
      r_kc <= '0;
      r_pwm <= INV;
    end else begin
      r_tgt <= w_tgt;
      r_cur <= w_cur;
      r_st <= w_st;
      r_kc <= w_kc;
      r_pwm <= (i_cnt < w_eff) ^ INV;
    end
  end
endmodule

// File: rtl/fan_pwm_ctrl.sv
// fan_pwm_ctrl: shared period counter and tick driving CH kick-start/ramping PWM channels
module fan_pwm_ctrl
  import fan_pwm_pkg::*;
#(
  parameter int CH     = 4,
  parameter int W      = 8,
  parameter int STEP   = 4,
  parameter int KICK   = 2,
  parameter int INVERT = 0
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          wr_en,
  input  logic [3:0]    wr_ch,
  input  logic [W-1:0]  wr_duty,
  output logic [CH-1:0] pwm_out,
  output logic [CH-1:0] busy,
  output logic          period_tick
);
  localparam int PER = period_of(W);
  logic [W-1:0] r_cnt;
  logic         r_tick, w_bnd;
  assign w_bnd = r_cnt == W'(PER - 1);
  assign period_tick = r_tick;
  always_ff @(posedge clk) begin
    if (arst) begin
      r_cnt <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt <= w_bnd ? '0 : r_cnt + W'(1);
      r_tick <= w_bnd;
    end
  end
  genvar g;
  generate
    for (g = 0; g < CH; g++) begin : g_ch
      fan_pwm_channel #(.W(W), .STEP(STEP), .KICK(KICK), .INVERT(INVERT)) u_ch (
        .clk    (clk),
        .arst   (arst),
        .i_wr   (wr_en && wr_ch == 4'(g)),
        .i_duty (wr_duty),
        .i_cnt  (r_cnt),
        .i_bnd  (w_bnd),
        .o_pwm  (pwm_out[g]),
        .o_busy (busy[g])
      );
    end
  endgenerate
endmodule
